// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch / branch-resolution path.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            hit;
        logic            taken;
        logic [XLEN-1:0] pred_pc;
    } pred_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-order queue of fetched branches awaiting resolution.
module pred_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  pred_entry_t   data_i,
    input  logic          pop_i,
    input  logic          clear_i,
    output logic          ready_o,
    output logic [AW:0]   count_o,
    output pred_entry_t   head_o
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    pred_entry_t         mem_q [DEPTH];
    pred_entry_t         mem_d [DEPTH];
    logic        [AW-1:0] wr_q, wr_d;
    logic        [AW-1:0] rd_q, rd_d;
    logic        [AW:0]   cnt_q, cnt_d;
    logic                 do_push;
    logic                 do_pop;

    // Readiness depends only on the registered count, so a pop never
    // frees a slot for a push in the same cycle.
    assign ready_o = (cnt_q != FULL);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        do_push = push_i & ready_o;
        do_pop  = pop_i & (cnt_q != '0);
        if (clear_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = data_i;
                wr_d        = wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_d = rd_q + 1'b1;
            end
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pred_resolve.sv
// Compares resolved branches against their predictions, raises redirects
// and produces the predictor training stream.
module pred_resolve
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_push_i,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic            if_pred_hit_i,
    input  logic            if_pred_taken_i,
    input  logic [XLEN-1:0] if_pred_pc_i,
    output logic            if_ready_o,
    input  logic            bu_res_v_i,
    input  logic [XLEN-1:0] bu_pc_i,
    input  logic            bu_taken_i,
    input  logic [XLEN-1:0] bu_target_i,
    input  logic            flush_i,
    output logic            pred_en_o,
    output logic [XLEN-1:0] bu_pc_branch_o,
    output logic [XLEN-1:0] bu_pc_target_o,
    output logic            bu_pred_success_q_o,
    output logic            bu_pred_failed_q_o,
    output logic            redirect_v_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            err_o,
    output logic [31:0]     hit_cnt_o,
    output logic [31:0]     miss_cnt_o
);

    localparam int AW = $clog2(DEPTH);

    pred_entry_t     push_ent;
    pred_entry_t     head;
    logic [AW:0]     count;
    logic            res, res_ok, empty, pc_bad, mispred;
    logic [XLEN-1:0] act_next, pred_next;

    logic            pred_en_q, pred_en_d;
    logic [XLEN-1:0] pc_branch_q, pc_branch_d;
    logic [XLEN-1:0] pc_target_q, pc_target_d;
    logic            success_q, success_d;
    logic            failed_q, failed_d;
    logic            redirect_v_q, redirect_v_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            err_q, err_d;
    logic [31:0]     hit_cnt_q, hit_cnt_d;
    logic [31:0]     miss_cnt_q, miss_cnt_d;

    assign push_ent = '{pc: if_pc_i, hit: if_pred_hit_i,
                        taken: if_pred_taken_i, pred_pc: if_pred_pc_i};

    pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (if_push_i & ~flush_i),
        .data_i  (push_ent),
        .pop_i   (res_ok),
        .clear_i (flush_i | mispred),
        .ready_o (if_ready_o),
        .count_o (count),
        .head_o  (head)
    );

    always_comb begin
        empty     = (count == '0);
        res       = bu_res_v_i & ~flush_i;
        res_ok    = res & ~empty;
        pc_bad    = (head.pc != bu_pc_i);
        act_next  = bu_taken_i ? bu_target_i
                               : bu_pc_i + XLEN'(INSTR_BYTES);
        pred_next = (head.hit & head.taken) ? head.pred_pc
                                            : head.pc + XLEN'(INSTR_BYTES);
        // A head PC mismatch means the queue is out of sync; refetch.
        mispred   = res_ok & (pc_bad | (pred_next != act_next));

        pred_en_d     = res_ok & (head.hit | bu_taken_i);
        pc_branch_d   = pred_en_d ? bu_pc_i : '0;
        pc_target_d   = pred_en_d ? bu_target_i : '0;
        success_d     = res_ok & head.hit & bu_taken_i;
        failed_d      = res_ok & head.hit & ~bu_taken_i;
        redirect_v_d  = mispred;
        redirect_pc_d = mispred ? act_next : '0;
        err_d         = err_q | (res & (empty | pc_bad));
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        if (res_ok & ~mispred) hit_cnt_d = sat_inc(hit_cnt_q);
        if (mispred) miss_cnt_d = sat_inc(miss_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_en_q     <= 1'b0;
            pc_branch_q   <= '0;
            pc_target_q   <= '0;
            success_q     <= 1'b0;
            failed_q      <= 1'b0;
            redirect_v_q  <= 1'b0;
            redirect_pc_q <= '0;
            err_q         <= 1'b0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            pred_en_q     <= pred_en_d;
            pc_branch_q   <= pc_branch_d;
            pc_target_q   <= pc_target_d;
            success_q     <= success_d;
            failed_q      <= failed_d;
            redirect_v_q  <= redirect_v_d;
            redirect_pc_q <= redirect_pc_d;
            err_q         <= err_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign pred_en_o           = pred_en_q;
    assign bu_pc_branch_o      = pc_branch_q;
    assign bu_pc_target_o      = pc_target_q;
    assign bu_pred_success_q_o = success_q;
    assign bu_pred_failed_q_o  = failed_q;
    assign redirect_v_o        = redirect_v_q;
    assign redirect_pc_o       = redirect_pc_q;
    assign err_o               = err_q;
    assign hit_cnt_o           = hit_cnt_q;
    assign miss_cnt_o          = miss_cnt_q;

endmodule

// File: tb/tb_pred_resolve.sv
// Directed bench for pred_resolve: hits, mispredicts, full queue, errors.
module tb_pred_resolve;
    import riscv_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            if_push_i;
    logic [XLEN-1:0] if_pc_i;
    logic            if_pred_hit_i;
    logic            if_pred_taken_i;
    logic [XLEN-1:0] if_pred_pc_i;
    logic            if_ready_o;
    logic            bu_res_v_i;
    logic [XLEN-1:0] bu_pc_i;
    logic            bu_taken_i;
    logic [XLEN-1:0] bu_target_i;
    logic            flush_i;
    logic            pred_en_o;
    logic [XLEN-1:0] bu_pc_branch_o;
    logic [XLEN-1:0] bu_pc_target_o;
    logic            bu_pred_success_q_o;
    logic            bu_pred_failed_q_o;
    logic            redirect_v_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            err_o;
    logic [31:0]     hit_cnt_o;
    logic [31:0]     miss_cnt_o;

    int checks   = 0;
    int failures = 0;

    pred_resolve #(.DEPTH(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .if_push_i           (if_push_i),
        .if_pc_i             (if_pc_i),
        .if_pred_hit_i       (if_pred_hit_i),
        .if_pred_taken_i     (if_pred_taken_i),
        .if_pred_pc_i        (if_pred_pc_i),
        .if_ready_o          (if_ready_o),
        .bu_res_v_i          (bu_res_v_i),
        .bu_pc_i             (bu_pc_i),
        .bu_taken_i          (bu_taken_i),
        .bu_target_i         (bu_target_i),
        .flush_i             (flush_i),
        .pred_en_o           (pred_en_o),
        .bu_pc_branch_o      (bu_pc_branch_o),
        .bu_pc_target_o      (bu_pc_target_o),
        .bu_pred_success_q_o (bu_pred_success_q_o),
        .bu_pred_failed_q_o  (bu_pred_failed_q_o),
        .redirect_v_o        (redirect_v_o),
        .redirect_pc_o       (redirect_pc_o),
        .err_o               (err_o),
        .hit_cnt_o           (hit_cnt_o),
        .miss_cnt_o          (miss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic hit,
                        input logic tk, input logic [31:0] ppc);
        if_push_i       = 1'b1;
        if_pc_i         = pc;
        if_pred_hit_i   = hit;
        if_pred_taken_i = tk;
        if_pred_pc_i    = ppc;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt);
        bu_res_v_i  = 1'b1;
        bu_pc_i     = pc;
        bu_taken_i  = tk;
        bu_target_i = tgt;
    endtask

    task automatic idle();
        if_push_i  = 1'b0;
        bu_res_v_i = 1'b0;
        flush_i    = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_en"}, pred_en_o, 0);
        chk({tag, "_rv"}, redirect_v_o, 0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        push(0, 0, 0, 0);
        resolve(0, 0, 0);
        idle();
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", if_ready_o, 1);
        chk("rst_en", pred_en_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_hit", hit_cnt_o, 0);
        chk("rst_rpc", redirect_pc_o, 0);

        // correct hit, taken
        push(32'h100, 1, 1, 32'h200);
        tick();
        idle();
        resolve(32'h100, 1, 32'h200);
        tick();
        idle();
        chk("t1_en", pred_en_o, 1);
        chk("t1_succ", bu_pred_success_q_o, 1);
        chk("t1_fail", bu_pred_failed_q_o, 0);
        chk("t1_rv", redirect_v_o, 0);
        chk("t1_hit", hit_cnt_o, 1);
        chk("t1_pcb", bu_pc_branch_o, 32'h100);
        chk("t1_pct", bu_pc_target_o, 32'h200);
        tick();
        chk_quiet("t1_pulse");

        // miss, actually taken
        push(32'h100, 0, 0, 0);
        tick();
        idle();
        resolve(32'h100, 1, 32'h180);
        tick();
        idle();
        chk("t2_en", pred_en_o, 1);
        chk("t2_succ", bu_pred_success_q_o, 0);
        chk("t2_fail", bu_pred_failed_q_o, 0);
        chk("t2_rv", redirect_v_o, 1);
        chk("t2_rpc", redirect_pc_o, 32'h180);
        chk("t2_miss", miss_cnt_o, 1);

        // hit taken, resolves not-taken
        push(32'h300, 1, 1, 32'h400);
        tick();
        idle();
        resolve(32'h300, 0, 32'h400);
        tick();
        idle();
        chk("t3_en", pred_en_o, 1);
        chk("t3_fail", bu_pred_failed_q_o, 1);
        chk("t3_succ", bu_pred_success_q_o, 0);
        chk("t3_rv", redirect_v_o, 1);
        chk("t3_rpc", redirect_pc_o, 32'h304);
        chk("t3_miss", miss_cnt_o, 2);

        // full queue
        push(32'h10, 0, 0, 0); tick();
        push(32'h14, 0, 0, 0); tick();
        push(32'h18, 0, 0, 0); tick();
        chk("t4_ready3", if_ready_o, 1);
        push(32'h1c, 0, 0, 0); tick();
        chk("t4_full", if_ready_o, 0);
        push(32'h20, 0, 0, 0); tick();
        chk("t4_full5", if_ready_o, 0);
        push(32'h24, 0, 0, 0);
        resolve(32'h10, 0, 0);
        tick();
        bu_res_v_i = 1'b0;
        chk_quiet("t4_pop");
        chk("t4_hit", hit_cnt_o, 2);
        chk("t4_rdy_pop", if_ready_o, 1);
        tick();
        idle();
        chk("t4_refull", if_ready_o, 0);
        resolve(32'h14, 0, 0); tick();
        resolve(32'h18, 0, 0); tick();
        resolve(32'h1c, 0, 0); tick();
        resolve(32'h24, 0, 0); tick();
        idle();
        chk("t4_order_err", err_o, 0);
        chk("t4_hit6", hit_cnt_o, 6);
        chk_quiet("t4_nt_miss");

        // mispredict discards younger entries and same-cycle push
        push(32'h100, 0, 0, 0); tick();
        push(32'h110, 0, 0, 0); tick();
        push(32'h120, 0, 0, 0); tick();
        push(32'h130, 0, 0, 0);
        resolve(32'h100, 1, 32'h500);
        tick();
        idle();
        chk("t5_rv", redirect_v_o, 1);
        chk("t5_rpc", redirect_pc_o, 32'h500);
        chk("t5_miss", miss_cnt_o, 3);
        push(32'h600, 0, 0, 0); tick();
        push(32'h604, 0, 0, 0); tick();
        push(32'h608, 0, 0, 0); tick();
        chk("t5_cnt3", if_ready_o, 1);
        push(32'h60c, 0, 0, 0); tick();
        idle();
        chk("t5_cnt4", if_ready_o, 0);

        // flush with resolve
        flush_i = 1'b1;
        resolve(32'h600, 1, 32'h900);
        tick();
        idle();
        chk_quiet("t6_flush");
        chk("t6_ready", if_ready_o, 1);
        chk("t6_hit", hit_cnt_o, 6);
        chk("t6_miss", miss_cnt_o, 3);
        chk("t6_err", err_o, 0);

        // head PC mismatch
        push(32'h700, 0, 0, 0); tick();
        idle();
        resolve(32'h704, 0, 0);
        tick();
        idle();
        chk("t7_err", err_o, 1);
        chk("t7_rv", redirect_v_o, 1);
        chk("t7_rpc", redirect_pc_o, 32'h708);
        chk("t7_miss", miss_cnt_o, 4);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t8_err_clr", err_o, 0);

        // resolve on empty
        resolve(32'h100, 1, 32'h200);
        tick();
        idle();
        chk("t8_err", err_o, 1);
        chk_quiet("t8_empty");
        chk("t8_succ", bu_pred_success_q_o, 0);
        chk("t8_hit", hit_cnt_o, 0);
        tick();
        chk("t8_sticky", err_o, 1);

        // reset with pending pulse
        push(32'h100, 1, 1, 32'h200); tick();
        idle();
        resolve(32'h100, 1, 32'h200);
        tick();
        idle();
        chk("t9_pre", pred_en_o, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t9_en", pred_en_o, 0);
        chk("t9_succ", bu_pred_success_q_o, 0);
        chk("t9_pcb", bu_pc_branch_o, 0);
        chk("t9_err", err_o, 0);
        chk("t9_hit", hit_cnt_o, 0);
        chk("t9_ready", if_ready_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pred_resolve.md
# pred_resolve

Branch-resolution tracker at the consumer end of the branch predictor. It queues every fetched control-flow instruction together with the prediction fetch used for it. When the branch unit resolves the oldest one, it compares outcome against prediction, issues a registered redirect on mispredict and produces the registered update stream that trains the predictor. It sits between fetch, the branch unit and the predictor.

## Interface
- `XLEN`, from `riscv_pkg`: address width.
- `DEPTH`, 4: maximum in-flight unresolved branches; power of two, ≥2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_push_i`  in  1  fetch issues a branch/jump entry.
- `if_pc_i`  in  XLEN  PC of that instruction.
- `if_pred_hit_i`  in  1  predictor had a valid hit for it.
- `if_pred_taken_i`  in  1  predicted direction; ignored when no hit.
- `if_pred_pc_i`  in  XLEN  predicted target; ignored when no hit.
- `if_ready_o`  out  1  queue can accept a push this cycle.
- `bu_res_v_i`  in  1  branch unit resolves the oldest entry.
- `bu_pc_i`  in  XLEN  PC of the resolved instruction.
- `bu_taken_i`  in  1  actual direction.
- `bu_target_i`  in  XLEN  actual taken target.
- `flush_i`  in  1  pipeline flush (exception/trap); discards all entries.
- `pred_en_o`  out  1  predictor update strobe.
- `bu_pc_branch_o`  out  XLEN  branch PC for the update.
- `bu_pc_target_o`  out  XLEN  target for the update.
- `bu_pred_success_q_o`  out  1  on a hit, actual taken: counter moves toward taken.
- `bu_pred_failed_q_o`  out  1  on a hit, actual not taken: counter moves toward not-taken.
- `redirect_v_o`  out  1  mispredict redirect pulse.
- `redirect_pc_o`  out  XLEN  correct fetch PC.
- `err_o`  out  1  sticky protocol-error flag.
- `hit_cnt_o`, `miss_cnt_o`  out  32  correct and mispredicted resolution counters.

## Operation
- **Push:** accepted when `if_push_i & if_ready_o`. Entries are stored in order.
- **`if_ready_o`:** `count < DEPTH`. It is a function of registered state only.
- **Resolve:** when `bu_res_v_i` and the queue is non-empty, the head is popped.
- **Actual next PC:** `bu_target_i` if taken, else `bu_pc_i + 4`, computed modulo 2^XLEN.
- **Predicted next PC:** `if_pred_pc` if hit and predicted taken, else `pc + 4`.
- **Mispredict:** predicted next PC differs from actual next PC.
- **Predictor update:**
  - `pred_en_o` asserts when the head hit, or when the branch was actually taken.
  - `bu_pc_branch_o` is `bu_pc_i`; `bu_pc_target_o` is `bu_target_i`.
  - `success`/`failed` assert only on a hit; exactly one of them, selected by `bu_taken_i`.
  - A miss that resolves not-taken produces no update.
- **Mispredict handling:**
  - `redirect_v_o` asserts with `redirect_pc_o` set to the actual next PC.
  - The whole queue is cleared, including any push in the same cycle (wrong path).
- **Head PC mismatch:** if `bu_pc_i` differs from the head PC, `err_o` sets and the event is treated as a mispredict.
- **Resolve on empty queue:** `err_o` sets, nothing is popped, no update and no redirect.
- **`flush_i`:** clears the queue and drops any same-cycle push and resolve. No redirect and no update are produced. It has priority over everything except `reset`.
- **Counters:** hit increments on each correct resolution, miss on each mispredict. Both saturate at all-ones.
- **`err_o`:** cleared only by `reset`.

## Timing
- Push visible at the head the cycle after acceptance; resolve of that entry is legal from then on.
- Compare logic is combinational on the resolve cycle.
- All outputs except `if_ready_o` are registered: they appear the cycle after `bu_res_v_i`, as single-cycle pulses.
- Queue clear on mispredict takes effect at the same edge that raises `redirect_v_o`.
- When full, a simultaneous pop frees a slot only from the next cycle; a push in that cycle is not accepted.
- Pointers wrap modulo DEPTH. `count` spans 0..DEPTH, which needs log2(DEPTH)+1 bits.
- On `reset`, all outputs are 0 and `if_ready_o` is 1:
  - pulses, PC buses and counters are 0;
  - queue is empty and `err_o` is clear.
- Reset asserted mid-operation discards entries and pending pulses at that edge.

## Structure
- Shared package `riscv_pkg`:
  - `pred_entry_t`, a packed struct {pc, hit, taken, pred_pc};
  - `INSTR_BYTES = 4`.
- Sub-module `pred_fifo`: a synchronous FIFO of `pred_entry_t` with push, pop, clear, count and head outputs.
- Compare logic, output registers and counters live in `pred_resolve`.

## Test plan
- **Correct hit, taken:** push pc=0x100 hit taken pred_pc=0x200; resolve taken target 0x200 → next cycle `pred_en`=1, success=1, no redirect, hit_cnt=1.
- **Miss, taken:** push pc=0x100 no hit; resolve taken target 0x180 → `pred_en`=1, success=0, failed=0, redirect 0x180, miss_cnt=1, queue empty.
- **Hit taken, resolves not-taken:** push pc=0x300 hit taken; resolve not taken → failed=1, redirect 0x304.
- **Full queue:** push 4 entries → `if_ready_o`=0; 5th push ignored. Pop plus push in the same cycle → push rejected; the next cycle accepts.
- **Mispredict discards younger entries:** entries 0x100, 0x110, 0x120; mispredict on head with a simultaneous push → count=0 and the push is dropped.
- **Errors and flush:**
  - resolve on empty → `err_o`=1, no pulses;
  - `flush_i` with resolve → no outputs, count=0;
  - `reset` → all outputs 0.
